// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: one partial product per cycle, N cycles per product,
// with sign handled by magnitude multiplication followed by an optional final negate.
module seq_multiplier #(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   x,
    input  logic [N-1:0]   y,
    input  logic           is_signed,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] z
);

    localparam int CW = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [N-1:0]     r_mcand;
    logic [2*N-1:0]   r_acc;
    logic [CW-1:0]    r_cnt;
    logic             r_neg;
    logic [2*N-1:0]   r_z;

    logic [N-1:0]     w_xmag;
    logic [N-1:0]     w_ymag;
    logic [N:0]       w_sum;
    logic [2*N-1:0]   w_acc_nxt;
    logic             w_last;

    function automatic logic [N-1:0] magnitude(input logic [N-1:0] v, input logic sgn);
        return (sgn && v[N-1]) ? -v : v;
    endfunction

    function automatic logic [2*N-1:0] apply_sign(input logic [2*N-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    assign w_xmag = magnitude(x, is_signed);
    assign w_ymag = magnitude(y, is_signed);

    // The low half of the accumulator holds the not-yet-consumed multiplier bits.
    assign w_sum     = {1'b0, r_acc[2*N-1:N]} + {1'b0, r_mcand};
    assign w_acc_nxt = r_acc[0] ? {w_sum, r_acc[N-1:1]} : {1'b0, r_acc[2*N-1:1]};
    assign w_last    = (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_state_nxt = BUSY;
            BUSY:    if (w_last)    w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_neg   <= 1'b0;
            r_z     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_mcand <= w_xmag;
                        r_acc   <= {{N{1'b0}}, w_ymag};
                        r_cnt   <= '0;
                        r_neg   <= is_signed & (x[N-1] ^ y[N-1]);
                    end
                end
                BUSY: begin
                    r_acc <= w_acc_nxt;
                    r_cnt <= r_cnt + CW'(1);
                    // Result is formed on the final step so it is ready the cycle DONE is entered.
                    if (w_last) begin
                        r_z <= apply_sign(w_acc_nxt, r_neg);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign z         = r_z;

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier (N = 8): directed vectors with hand-computed products,
// backpressure, reset and bubble cases, plus a short randomized pass with a reference product.
module tb_seq_multiplier;

    localparam int N = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [N-1:0]  x = '0;
    logic [N-1:0]  y = '0;
    logic          is_signed = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [2*N-1:0] z;

    seq_multiplier #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .is_signed (is_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] exp_q [$];
    int unsigned acc_q [$];

    // 0 = hold out_ready low, 1 = hold high, 2 = random stalls
    int rdy_mode = 0;

    task automatic check(input bit ok, input string name, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h at cycle %0d", name, act, req, cyc);
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: sample at the falling edge, where all DUT outputs are settled.
    logic        prev_ov = 1'b0;
    logic        prev_hs = 1'b0;
    logic [15:0] prev_z  = '0;

    always @(negedge clk) begin
        if (rst) begin
            prev_ov = 1'b0;
            prev_hs = 1'b0;
        end else begin
            if (out_valid)
                check(in_ready == 1'b0, "in_ready_low_in_done", 16'(in_ready), 16'h0);
            if (prev_ov && !prev_hs) begin
                check(out_valid == 1'b1, "out_valid_held", 16'(out_valid), 16'h1);
                check(z == prev_z, "z_held", z, prev_z);
            end
            if (out_valid && !prev_ov) begin
                if (acc_q.size() == 0)
                    check(1'b0, "unexpected_out_valid", z, 16'h0);
                else
                    check(cyc - acc_q[0] == 8, "latency", 16'(cyc - acc_q[0]), 16'd8);
            end
            if (out_valid && out_ready && exp_q.size() != 0) begin
                check(z == exp_q[0], "product", z, exp_q[0]);
                void'(exp_q.pop_front());
                void'(acc_q.pop_front());
            end
            prev_ov = out_valid;
            prev_hs = out_valid && out_ready;
            prev_z  = z;
        end
    end

    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic s, input logic [15:0] e);
        int waited;
        @(posedge clk); #1;
        in_valid  = 1'b1;
        x         = a;
        y         = b;
        is_signed = s;
        waited    = 0;
        forever begin
            @(negedge clk);
            if (in_ready && !rst) break;
            waited++;
            if (waited > 100) begin
                check(1'b0, "accept_timeout", 16'(waited), 16'd0);
                break;
            end
        end
        exp_q.push_back(e);
        acc_q.push_back(cyc + 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_ov();
        int waited = 0;
        while (!out_valid) begin
            @(negedge clk);
            waited++;
            if (waited > 50) begin
                check(1'b0, "out_valid_timeout", 16'(waited), 16'd0);
                break;
            end
        end
    endtask

    task automatic drain();
        int waited = 0;
        rdy_mode = 1;
        while (exp_q.size() != 0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (exp_q.size() != 0) check(1'b0, "drain_timeout", 16'(exp_q.size()), 16'd0);
    endtask

    typedef struct { logic [7:0] a; logic [7:0] b; logic s; logic [15:0] e; } vec_t;
    vec_t vecs [10] = '{
        '{8'hFF, 8'hFF, 1'b0, 16'hFE01},
        '{8'h80, 8'h80, 1'b1, 16'h4000},
        '{8'h80, 8'h7F, 1'b1, 16'hC080},
        '{8'hFD, 8'h05, 1'b1, 16'hFFF1},
        '{8'h00, 8'hFD, 1'b1, 16'h0000},
        '{8'hFF, 8'hFF, 1'b1, 16'h0001},
        '{8'h7F, 8'h7F, 1'b1, 16'h3F01},
        '{8'hFF, 8'h01, 1'b1, 16'hFFFF},
        '{8'h80, 8'h80, 1'b0, 16'h4000},
        '{8'h0C, 8'h0D, 1'b0, 16'h009C}
    };

    initial begin
        logic [7:0]  ra, rb;
        logic        rs;
        logic [15:0] re;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check(in_ready == 1'b1, "reset_in_ready", 16'(in_ready), 16'h1);
        check(out_valid == 1'b0, "reset_out_valid", 16'(out_valid), 16'h0);
        check(z == 16'h0, "reset_z", z, 16'h0);

        // Directed vectors, consumer always ready.
        rdy_mode = 1;
        foreach (vecs[i]) issue(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].e);
        drain();

        // Backpressure with noise on the input side while waiting in DONE.
        rdy_mode = 0;
        issue(8'h11, 8'h0F, 1'b0, 16'h00FF);
        wait_ov();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            in_valid  = 1'(i & 1);
            x         = 8'($urandom);
            y         = 8'($urandom);
            is_signed = 1'($urandom);
            @(negedge clk);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        rdy_mode = 1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check(out_valid == 1'b0, "after_hs_out_valid", 16'(out_valid), 16'h0);
        check(in_ready == 1'b1, "after_hs_in_ready", 16'(in_ready), 16'h1);

        // Handshake coinciding with in_valid: the new request must wait one bubble cycle.
        rdy_mode = 0;
        issue(8'h06, 8'h07, 1'b0, 16'h002A);
        wait_ov();
        rdy_mode = 1;
        issue(8'hF9, 8'h09, 1'b1, 16'hFFC1);
        drain();

        // Reset on the 4th BUSY cycle, with in_valid also high during reset.
        rdy_mode = 1;
        issue(8'h05, 8'h07, 1'b0, 16'h0023);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        in_valid = 1'b1;
        x = 8'h55;
        y = 8'h66;
        is_signed = 1'b0;
        exp_q.delete();
        acc_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check(in_ready == 1'b1, "rst_mid_in_ready", 16'(in_ready), 16'h1);
        check(out_valid == 1'b0, "rst_mid_out_valid", 16'(out_valid), 16'h0);
        check(z == 16'h0, "rst_mid_z", z, 16'h0);
        @(negedge clk);
        check(in_ready == 1'b1, "rst_no_capture", 16'(in_ready), 16'h1);
        issue(8'h03, 8'h04, 1'b0, 16'h000C);
        drain();

        // Randomized pass with stalls against a reference product.
        rdy_mode = 2;
        for (int i = 0; i < 200; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rs = 1'($urandom);
            if (rs) re = 16'($signed({{8{ra[7]}}, ra}) * $signed({{8{rb[7]}}, rb}));
            else    re = {8'h00, ra} * {8'h00, rb};
            issue(ra, rb, rs, re);
        end
        drain();

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
